// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types for the round-robin lock arbiter.
package rr_lock_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin find-first: rotate by ptr, priority-pick, un-rotate.
module rr_pick #(
    parameter int REQS      = 4,
    parameter int IDX_WIDTH = $clog2(REQS)
) (
    input  logic [REQS-1:0]      req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    // ptr < REQS and off < REQS, so a single subtract gives the modulo.
    function automatic logic [IDX_WIDTH-1:0] wrap_add(logic [IDX_WIDTH-1:0] base, int off);
        int s;
        s = int'(base) + off;
        if (s >= REQS) s = s - REQS;
        return IDX_WIDTH'(s);
    endfunction

    logic [REQS-1:0] rot;
    int              first;

    always_comb begin
        rot = '0;
        for (int j = 0; j < REQS; j++) begin
            rot[j] = req[wrap_add(ptr, j)];
        end
    end

    always_comb begin
        found = 1'b0;
        first = 0;
        for (int j = 0; j < REQS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                first = j;
            end
        end
        idx = wrap_add(ptr, first);
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the grant to its owner while it keeps
// requesting, with optional forced hand-over after HOLD_MAX cycles.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int REQS      = 4,
    parameter int IDX_WIDTH = $clog2(REQS),
    parameter int HOLD_MAX  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQS-1:0]      req,
    output logic [REQS-1:0]      grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_vld
);

    state_t                state;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  pick_idx;
    logic [REQS-1:0]       owner_oh;
    logic [REQS-1:0]       others;
    logic [REQS-1:0]       pick_req;
    logic                  owner_req;
    logic                  hold_full;
    logic                  preempt;
    logic                  found;
    logic                  take;
    logic                  drop;

    assign owner_oh  = REQS'(1) << grant_idx;
    assign owner_req = |(req & owner_oh);
    assign others    = req & ~owner_oh;

    generate
        if (HOLD_MAX > 0) begin : g_hold
            localparam int HW = $clog2(HOLD_MAX + 1);
            logic [HW-1:0] hold_cnt;

            assign hold_full = (hold_cnt >= HW'(HOLD_MAX));

            always_ff @(posedge clk) begin
                if (reset)
                    hold_cnt <= '0;
                else if (take)
                    hold_cnt <= HW'(1);
                else if (state == ST_BUSY && owner_req && !hold_full)
                    hold_cnt <= hold_cnt + 1'b1;
            end
        end else begin : g_nohold
            assign hold_full = 1'b0;
        end
    endgenerate

    // Preemption re-picks with the owner masked so the lock actually moves on.
    assign preempt  = (state == ST_BUSY) && owner_req && hold_full && (|others);
    assign pick_req = preempt ? others : req;

    rr_pick #(
        .REQS      (REQS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    assign take = found && ((state == ST_IDLE) || !owner_req || preempt);
    assign drop = (state == ST_BUSY) && !owner_req && !found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
        end else if (take) begin
            state     <= ST_BUSY;
            grant_idx <= pick_idx;
            grant_vld <= 1'b1;
            ptr       <= (pick_idx == IDX_WIDTH'(REQS - 1)) ? '0 : pick_idx + 1'b1;
        end else if (drop) begin
            state     <= ST_IDLE;
            grant_vld <= 1'b0;
        end
    end

    // Decoded from registered state only; no path from req.
    assign grant = grant_vld ? owner_oh : '0;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench: three arbiter configurations driven from one vector table.
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_a, req_b;
    logic [2:0] req_c;
    logic [3:0] g_a, g_b;
    logic [2:0] g_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       vld_a, vld_b, vld_c;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.REQS(4), .HOLD_MAX(0)) u_a (
        .clk(clk), .reset(reset), .req(req_a),
        .grant(g_a), .grant_idx(idx_a), .grant_vld(vld_a));

    rr_lock_arbiter #(.REQS(4), .HOLD_MAX(3)) u_b (
        .clk(clk), .reset(reset), .req(req_b),
        .grant(g_b), .grant_idx(idx_b), .grant_vld(vld_b));

    rr_lock_arbiter #(.REQS(3), .HOLD_MAX(0)) u_c (
        .clk(clk), .reset(reset), .req(req_c),
        .grant(g_c), .grant_idx(idx_c), .grant_vld(vld_c));

    typedef struct {
        int         dut;
        bit         rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
        bit         vld;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(int d, bit r, logic [3:0] q, logic [3:0] g, logic [1:0] i, bit v);
        vec_t e;
        e.dut = d; e.rst = r; e.req = q; e.grant = g; e.idx = i; e.vld = v;
        vecs.push_back(e);
    endtask

    task automatic check(string name, int n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", name, n, act, exp);
        end
    endtask

    task automatic drive(int d, bit r, logic [3:0] q);
        reset = r;
        req_a = (d == 0) ? q : 4'd0;
        req_b = (d == 1) ? q : 4'd0;
        req_c = (d == 2) ? q[2:0] : 3'd0;
    endtask

    task automatic sample(int d, output logic [3:0] g, output logic [1:0] i, output logic v);
        case (d)
            0:       begin g = g_a;         i = idx_a; v = vld_a; end
            1:       begin g = g_b;         i = idx_b; v = vld_b; end
            default: begin g = {1'b0, g_c}; i = idx_c; v = vld_c; end
        endcase
    endtask

    // One edge: drive at negedge, check outputs just after the following posedge.
    task automatic step(int n, int d, bit r, logic [3:0] q,
                        logic [3:0] eg, logic [1:0] ei, bit ev);
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
        @(negedge clk);
        drive(d, r, q);
        @(posedge clk);
        #1;
        sample(d, g, i, v);
        check($sformatf("grant[d%0d]", d), n, 32'(g), 32'(eg));
        check($sformatf("grant_idx[d%0d]", d), n, 32'(i), 32'(ei));
        check($sformatf("grant_vld[d%0d]", d), n, 32'(v), 32'(ev));
        if (v) check($sformatf("onehot[d%0d]", d), n, 32'(g), 32'(4'd1 << i));
        else   check($sformatf("zero_grant[d%0d]", d), n, 32'(g), 32'd0);
        if (d == 2) check("idx_range", n, 32'(i < 2'd3), 32'd1);
    endtask

    initial begin
        logic [3:0] g;
        logic [1:0] i;
        logic       v;

        reset = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;

        // REQS=4, unlimited lock: single requester, then rotation with wrap.
        add(0, 1, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 11; k++) add(0, 0, 4'b0001, 4'b0001, 0, 1);
        add(0, 0, 4'b1111, 4'b0001, 0, 1);
        add(0, 0, 4'b1110, 4'b0010, 1, 1);
        add(0, 0, 4'b1111, 4'b0010, 1, 1);
        add(0, 0, 4'b1111, 4'b0010, 1, 1);
        add(0, 0, 4'b1101, 4'b0100, 2, 1);
        add(0, 0, 4'b1111, 4'b0100, 2, 1);
        add(0, 0, 4'b1111, 4'b0100, 2, 1);
        add(0, 0, 4'b1011, 4'b1000, 3, 1);
        add(0, 0, 4'b1111, 4'b1000, 3, 1);
        add(0, 0, 4'b1111, 4'b1000, 3, 1);
        add(0, 0, 4'b0111, 4'b0001, 0, 1);
        // Owner 2 releases alone: idle with last index kept, then ptr=3 wins.
        add(0, 0, 4'b0100, 4'b0100, 2, 1);
        add(0, 0, 4'b0100, 4'b0100, 2, 1);
        add(0, 0, 4'b0000, 4'b0000, 2, 0);
        add(0, 0, 4'b0000, 4'b0000, 2, 0);
        add(0, 0, 4'b1001, 4'b1000, 3, 1);

        // HOLD_MAX=3: two requesters trade every 3 cycles, then lone owner holds.
        add(1, 1, 4'b0011, 4'b0000, 0, 0);
        for (int k = 0; k < 12; k++)
            add(1, 0, 4'b0011, 4'd1 << ((k / 3) % 2), 2'((k / 3) % 2), 1);
        for (int k = 0; k < 10; k++) add(1, 0, 4'b0001, 4'b0001, 0, 1);

        // REQS=3: order 0,1,2,0 then up to owner 2.
        add(2, 1, 4'b0111, 4'b0000, 0, 0);
        add(2, 0, 4'b0111, 4'b0001, 0, 1);
        add(2, 0, 4'b0110, 4'b0010, 1, 1);
        add(2, 0, 4'b0111, 4'b0010, 1, 1);
        add(2, 0, 4'b0101, 4'b0100, 2, 1);
        add(2, 0, 4'b0111, 4'b0100, 2, 1);
        add(2, 0, 4'b0011, 4'b0001, 0, 1);
        add(2, 0, 4'b0110, 4'b0010, 1, 1);
        add(2, 0, 4'b0101, 4'b0100, 2, 1);

        for (int n = 0; n < vecs.size(); n++)
            step(n, vecs[n].dut, vecs[n].rst, vecs[n].req,
                 vecs[n].grant, vecs[n].idx, vecs[n].vld);

        // Reset while owner 2 holds drops everything; restart grants 0.
        step(1000, 2, 1, 4'b0111, 4'b0000, 0, 0);
        step(1001, 2, 0, 4'b0111, 4'b0001, 0, 1);

        // HOLD_MAX=3 with all four requesting: each owner gets exactly 3 cycles.
        step(2000, 1, 1, 4'b1111, 4'b0000, 0, 0);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            drive(1, 0, 4'b1111);
            @(posedge clk);
            #1;
            sample(1, g, i, v);
            check("preempt_rotation", 2001 + k, 32'(i), 32'((k / 3) % 4));
            check("preempt_vld", 2001 + k, 32'(v), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
